// File: rtl/uart_tx_parity.sv
// UART transmitter: start, DBIT data bits LSB first, optional even parity, stop.
// Parity stage is present only when UART_TX_PARITY_EN is defined.
module uart_tx_parity #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  // Stop bit may need more than 16 strobes (1.5 or 2 stop bits).
  localparam int CNT_W = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             done_reg;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg;
`endif

  logic bit_end;
  logic stop_end;

  assign bit_end  = s_tick && (cnt_reg == CNT_W'(15));
  assign stop_end = s_tick && (cnt_reg == CNT_W'(SB_TICK - 1));

  // tx_reg is loaded with the level of the state being entered, so the
  // line changes on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (tx_start) begin
            shift_reg  <= din;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^din[DBIT-1:0];
`endif
            cnt_reg    <= '0;
            state_reg  <= START;
            tx_reg     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
          end else if (s_tick) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_reg == 3'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_reg <= bit_reg + 3'd1;
              tx_reg  <= shift_reg[1];
            end
          end else if (s_tick) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end else if (s_tick) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          tx_reg <= 1'b1;
          if (stop_end) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end else if (s_tick) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity; line levels checked at each bit centre.
// Expected frames follow UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_parity;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  int n_vec = 0;
  int n_err = 0;

`ifdef UART_TX_PARITY_EN
  localparam int    EXP_TICKS = 176;
  localparam string F55 = "01010101001";
  localparam string F07 = "01110000011";
  localparam string F3C = "00011110001";
  localparam string FA5 = "01010010101";
`else
  localparam int    EXP_TICKS = 160;
  localparam string F55 = "0101010101";
  localparam string F07 = "0111000001";
  localparam string F3C = "0001111001";
  localparam string FA5 = "0101001011";
`endif

  uart_tx_parity #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // One-cycle baud strobe every fourth clock, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic chk(input logic obs, input logic exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input int obs, input int exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input string exp, input bit pre,
                           input int inject_at, input int abort_at,
                           input bit chain, input logic [7:0] chain_d,
                           input string tag);
    int  ticks;
    int  idx;
    bit  got_done;
    bit  injected;
    bit  hold;
    ticks = 0; got_done = 0; injected = 0; hold = 0;
    if (!pre) begin
      @(negedge clk);
      din = d;
      tx_start = 1'b1;
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk(tx, 1'b0, {tag, "_start_edge_tx"});
    chk(tx_busy, 1'b1, {tag, "_start_edge_busy"});
    chk(tx_done_tick, 1'b0, {tag, "_start_edge_done"});
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      @(posedge clk); #1;
      if (hold) begin
        tx_start = 1'b0;
        hold = 0;
      end
      if (s_tick) ticks++;
      if (s_tick && ticks == inject_at && !injected) begin
        tx_start = 1'b1;
        din = 8'hA5;
        injected = 1;
        hold = 1;
      end
      idx = ticks / 16;
      if (s_tick && (ticks % 16) == 8 && idx < exp.len()) begin
        chk(tx, exp[idx] == 8'h31, $sformatf("%s_bit%0d", tag, idx));
        chk(tx_busy, 1'b1, $sformatf("%s_busy%0d", tag, idx));
        if (ticks == abort_at) begin
          #2 reset = 1'b1;
          tx_start = 1'b1;
          #1;
          chk(tx, 1'b1, {tag, "_abort_tx"});
          chk(tx_busy, 1'b0, {tag, "_abort_busy"});
          chk(tx_done_tick, 1'b0, {tag, "_abort_done"});
          repeat (3) begin
            @(negedge clk);
            chk(tx, 1'b1, {tag, "_inreset_tx"});
            chk(tx_done_tick, 1'b0, {tag, "_inreset_done"});
          end
          reset = 1'b0;
          tx_start = 1'b0;
          repeat (40) begin
            @(posedge clk); #1;
            chk(tx, 1'b1, {tag, "_post_tx"});
            chk(tx_done_tick, 1'b0, {tag, "_post_done"});
          end
          return;
        end
      end
      if (tx_done_tick) begin
        got_done = 1;
        chk(tx_busy, 1'b0, {tag, "_done_busy"});
        chk_int(ticks, EXP_TICKS, {tag, "_frame_ticks"});
        if (chain) begin
          tx_start = 1'b1;
          din = chain_d;
        end else begin
          @(posedge clk); #1;
          chk(tx_done_tick, 1'b0, {tag, "_done_width"});
          chk(tx, 1'b1, {tag, "_idle_tx"});
          chk(tx_busy, 1'b0, {tag, "_idle_busy"});
        end
      end
    end
    chk(got_done, 1'b1, {tag, "_done_seen"});
  endtask

  initial begin
    reset = 1'b1;
    tx_start = 1'b1;
    din = 8'h55;
    #1;
    chk(tx, 1'b1, "rst_tx");
    chk(tx_busy, 1'b0, "rst_busy");
    chk(tx_done_tick, 1'b0, "rst_done");
    repeat (4) @(negedge clk);
    chk(tx, 1'b1, "rst_hold_tx");
    chk(tx_busy, 1'b0, "rst_hold_busy");
    reset = 1'b0;
    tx_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk(tx, 1'b1, "idle_tx");
      chk(tx_busy, 1'b0, "idle_busy");
      chk(tx_done_tick, 1'b0, "idle_done");
    end

    run_frame(8'h55, F55, 1'b0, -1, -1, 1'b0, 8'h00, "f55");
    run_frame(8'h07, F07, 1'b0, -1, -1, 1'b0, 8'h00, "f07");
    // Request during data bit 2 must be ignored; 0xA5 then chained on done.
    run_frame(8'h3C, F3C, 1'b0, 16 * 3 + 4, -1, 1'b1, 8'hA5, "f3c");
    run_frame(8'hA5, FA5, 1'b1, -1, -1, 1'b0, 8'h00, "fa5");
    run_frame(8'h55, F55, 1'b0, -1, 16 * 4 + 8, 1'b0, 8'h00, "abort");
    run_frame(8'h07, F07, 1'b0, -1, -1, 1'b0, 8'h00, "f07_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
